// File: rtl/ras_pkg.sv
// Shared types and jump classification for the return-address stack.
package ras_pkg;

  typedef enum logic [1:0] {
    NONE,
    PUSH,
    POP,
    POPPUSH
  } ras_op_e;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  // x1/x5 link-register hints decide what a JAL/JALR does to the stack.
  function automatic ras_op_e ras_classify(input logic [4:0] rs1,
                                           input logic [4:0] rd,
                                           input logic       is_jal);
    logic rd_l;
    logic rs1_l;
    rd_l  = (rd == LINK_X1) || (rd == LINK_X5);
    rs1_l = ((rs1 == LINK_X1) || (rs1 == LINK_X5)) && !is_jal;
    if (rd_l && rs1_l) begin
      return (rs1 == rd) ? PUSH : POPPUSH;
    end else if (rd_l) begin
      return PUSH;
    end else if (rs1_l) begin
      return POP;
    end
    return NONE;
  endfunction

endpackage

// File: rtl/ras_storage.sv
// DEPTH x XLEN register file: one synchronous write port, one asynchronous read port.
module ras_storage #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are deliberately not reset; count gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_predictor.sv
// Return-address stack with combinational return prediction and overflow/underflow counters.
// Optional checkpoint/restore of {tos,count} is enabled by defining RAS_CHECKPOINT_EN.
module ras_predictor
  import ras_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jump_valid,
  input  logic                     jump_is_jal,
  input  logic [XLEN-1:0]          jump_pc,
  input  logic [4:0]               jump_rs1,
  input  logic [4:0]               jump_rd,
`ifdef RAS_CHECKPOINT_EN
  input  logic                     ckpt_save,
  input  logic                     ckpt_restore,
`endif
  output logic                     pred_valid,
  output logic [XLEN-1:0]          pred_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         udf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ras_op_e         op;
  logic [AW-1:0]   tos;
  logic [AW-1:0]   tos_next;
  logic [CW-1:0]   count_next;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] link;
  logic            ovf_inc;
  logic            udf_inc;
  logic            empty;
  logic            full;
  logic            drop_jump;

`ifdef RAS_CHECKPOINT_EN
  logic [AW-1:0]   snap_tos;
  logic [CW-1:0]   snap_count;
  assign drop_jump = ckpt_restore;
`else
  assign drop_jump = 1'b0;
`endif

  assign link  = jump_pc + XLEN'(4);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign op    = (jump_valid && !drop_jump) ? ras_classify(jump_rs1, jump_rd, jump_is_jal) : NONE;

  ras_storage #(.DEPTH(DEPTH), .XLEN(XLEN)) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (link),
    .raddr (tos),
    .rdata (pred_addr)
  );

  // A POPPUSH on an empty stack degrades into a plain PUSH plus an underflow event.
  always_comb begin
    tos_next   = tos;
    count_next = count;
    we         = 1'b0;
    waddr      = tos;
    ovf_inc    = 1'b0;
    udf_inc    = 1'b0;
    pred_valid = 1'b0;
    case (op)
      PUSH: begin
        tos_next = tos + AW'(1);
        we       = 1'b1;
        waddr    = tos + AW'(1);
        if (full) begin
          ovf_inc = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      POP: begin
        if (!empty) begin
          pred_valid = 1'b1;
          tos_next   = tos - AW'(1);
          count_next = count - CW'(1);
        end else begin
          udf_inc = 1'b1;
        end
      end
      POPPUSH: begin
        we = 1'b1;
        if (!empty) begin
          pred_valid = 1'b1;
        end else begin
          udf_inc    = 1'b1;
          tos_next   = tos + AW'(1);
          waddr      = tos + AW'(1);
          count_next = count + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos     <= '0;
      count   <= '0;
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
`ifdef RAS_CHECKPOINT_EN
      if (ckpt_restore) begin
        tos   <= snap_tos;
        count <= snap_count;
      end else begin
        tos   <= tos_next;
        count <= count_next;
      end
`else
      tos   <= tos_next;
      count <= count_next;
`endif
      if (ovf_inc && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
      if (udf_inc && (udf_cnt != '1)) begin
        udf_cnt <= udf_cnt + CNT_W'(1);
      end
    end
  end

`ifdef RAS_CHECKPOINT_EN
  // The snapshot takes the pre-update pointers; a simultaneous restore wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_tos   <= '0;
      snap_count <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      snap_tos   <= tos;
      snap_count <= count;
    end
  end
`endif

endmodule
